// File: rtl/lsd_pkg.sv
// Shared types for the LSD result-buffer reader: FSM state encoding and the
// 64-bit segment beat layout presented to the PS side.
package lsd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_LOCK,
    S_WAIT,
    S_SEND,
    S_FIN
  } state_t;

  localparam int SEG_FIELD_W = 16;

  // start_v lands in the top 16 bits of the beat.
  typedef struct packed {
    logic [SEG_FIELD_W-1:0] start_v;
    logic [SEG_FIELD_W-1:0] start_h;
    logic [SEG_FIELD_W-1:0] end_v;
    logic [SEG_FIELD_W-1:0] end_h;
  } lsd_seg_t;

  function automatic lsd_seg_t pack_seg(input logic [SEG_FIELD_W-1:0] sv,
                                        input logic [SEG_FIELD_W-1:0] sh,
                                        input logic [SEG_FIELD_W-1:0] ev,
                                        input logic [SEG_FIELD_W-1:0] eh);
    lsd_seg_t s;
    s.start_v = sv;
    s.start_h = sh;
    s.end_v   = ev;
    s.end_h   = eh;
    return s;
  endfunction

endpackage

// File: rtl/lsd_buffer_reader.sv
// Drains one frame of line segments from the LSD result buffer. On start it
// waits for a completed frame, write-protects the buffer, then reads each
// segment and streams it out as a 64-bit valid/ready beat.
module lsd_buffer_reader
  import lsd_pkg::*;
#(
  parameter  int V_FRAME    = 750,
  parameter  int H_FRAME    = 1650,
  parameter  int RAM_SIZE   = 4096,
  parameter  int RD_LATENCY = 1,
  localparam int VW         = $clog2(V_FRAME),
  localparam int HW         = $clog2(H_FRAME),
  localparam int AW         = $clog2(RAM_SIZE)
) (
  input  logic          psclk,
  input  logic          rst,
  input  logic          start,
  input  logic          lsdbuf_ready,
  input  logic [AW-1:0] lsdbuf_line_num,
  input  logic [VW-1:0] lsdbuf_start_v,
  input  logic [HW-1:0] lsdbuf_start_h,
  input  logic [VW-1:0] lsdbuf_end_v,
  input  logic [HW-1:0] lsdbuf_end_h,
  output logic [AW-1:0] lsdbuf_raddr,
  output logic          lsdbuf_write_protect,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [63:0]   m_data,
  output logic          m_last,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] seg_count
);

  // Coordinates are zero-extended into 16-bit fields, never truncated.
  if (VW > SEG_FIELD_W || HW > SEG_FIELD_W) begin : g_width_chk
    $error("lsd_buffer_reader: coordinate width exceeds 16-bit beat field");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_lat_chk
    $error("lsd_buffer_reader: RD_LATENCY must be 1..4");
  end

  state_t     state, state_nx;
  logic [2:0] lat_cnt;
  logic       last_addr;

  // Current read address is the final segment of the latched frame.
  assign last_addr = (lsdbuf_raddr == seg_count - AW'(1));
  assign busy      = (state != S_IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge psclk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode.
  // NOTE: state_nx gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_ARM;
      S_ARM:  if (lsdbuf_ready) state_nx = S_LOCK;
      // Buffer is protected in LOCK, so line_num is stable here.
      S_LOCK: state_nx = (lsdbuf_line_num == '0) ? S_FIN : S_WAIT;
      S_WAIT: if (lat_cnt == 3'(RD_LATENCY - 1)) state_nx = S_SEND;
      S_SEND: if (m_ready) state_nx = last_addr ? S_FIN : S_WAIT;
      S_FIN:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Registered outputs, read address, latency counter and beat capture.
  // The read data for a new raddr is sampled on the edge that closes the
  // RD_LATENCY-th cycle after raddr changes, i.e. the WAIT->SEND edge, so
  // m_valid is high from the first SEND cycle and a beat completes every
  // RD_LATENCY+1 cycles with m_ready held high.
  always_ff @(posedge psclk) begin
    if (rst) begin
      lsdbuf_raddr         <= '0;
      lsdbuf_write_protect <= 1'b0;
      m_valid              <= 1'b0;
      m_data               <= '0;
      m_last               <= 1'b0;
      done                 <= 1'b0;
      seg_count            <= '0;
      lat_cnt              <= '0;
    end else begin
      lsdbuf_write_protect <= (state_nx == S_LOCK) || (state_nx == S_WAIT) ||
                              (state_nx == S_SEND);
      done                 <= (state_nx == S_FIN);
      m_valid              <= (state_nx == S_SEND);

      if (state == S_WAIT) lat_cnt <= lat_cnt + 3'd1;
      else                 lat_cnt <= '0;

      if (state == S_ARM && state_nx == S_LOCK) lsdbuf_raddr <= '0;
      if (state == S_LOCK) seg_count <= lsdbuf_line_num;
      if (state == S_SEND && m_ready && !last_addr)
        lsdbuf_raddr <= lsdbuf_raddr + AW'(1);

      // Beat is captured once on SEND entry and held through any stall.
      if (state == S_WAIT && state_nx == S_SEND) begin
        m_data <= pack_seg(SEG_FIELD_W'(lsdbuf_start_v), SEG_FIELD_W'(lsdbuf_start_h),
                           SEG_FIELD_W'(lsdbuf_end_v),   SEG_FIELD_W'(lsdbuf_end_h));
        m_last <= last_addr;
      end else if (state_nx != S_SEND) begin
        m_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsd_buffer_reader.sv
// Directed bench for lsd_buffer_reader: a table of frame transfers against a
// RD_LATENCY=1 instance, reset-mid-transfer, and a full-depth frame against a
// RD_LATENCY=3 instance with a matching delayed buffer model.
module tb_lsd_buffer_reader;

  localparam int VW = 10;
  localparam int HW = 11;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  always #5 clk = ~clk;

  // RD_LATENCY=1 instance
  logic          start, lsdbuf_ready, wp, m_valid, m_ready, m_last, busy, done;
  logic [AW-1:0] line_num, raddr, seg_count;
  logic [VW-1:0] sv, ev;
  logic [HW-1:0] sh, eh;
  logic [63:0]   m_data;

  // RD_LATENCY=3 instance
  logic          start3, ready3, wp3, m_valid3, m_ready3, m_last3, busy3, done3;
  logic [AW-1:0] line_num3, raddr3, seg_count3, ra_d1, ra_d2;
  logic [VW-1:0] sv3, ev3;
  logic [HW-1:0] sh3, eh3;
  logic [63:0]   m_data3;

  int n_checks = 0;
  int n_pass   = 0;

  // Buffer contents model: deterministic coordinates per address.
  function automatic int f_sv(int a); return (a * 7 + 3) % 750;     endfunction
  function automatic int f_sh(int a); return (a * 37 + 1601) % 1650; endfunction
  function automatic int f_ev(int a); return (a * 11 + 700) % 750;  endfunction
  function automatic int f_eh(int a); return (a * 53 + 9) % 1650;   endfunction

  function automatic logic [63:0] exp_beat(int a);
    logic [63:0] r;
    r = {16'(f_sv(a)), 16'(f_sh(a)), 16'(f_ev(a)), 16'(f_eh(a))};
    return r;
  endfunction

  // Latency-1 buffer: data for raddr is available within the same cycle.
  assign sv = VW'(f_sv(int'(raddr)));
  assign sh = HW'(f_sh(int'(raddr)));
  assign ev = VW'(f_ev(int'(raddr)));
  assign eh = HW'(f_eh(int'(raddr)));

  // Latency-3 buffer: two register stages on the address.
  always @(posedge clk) begin
    ra_d1 <= raddr3;
    ra_d2 <= ra_d1;
  end
  assign sv3 = VW'(f_sv(int'(ra_d2)));
  assign sh3 = HW'(f_sh(int'(ra_d2)));
  assign ev3 = VW'(f_ev(int'(ra_d2)));
  assign eh3 = HW'(f_eh(int'(ra_d2)));

  lsd_buffer_reader #(.RD_LATENCY(1)) u_dut (
    .psclk(clk), .rst(rst), .start(start), .lsdbuf_ready(lsdbuf_ready),
    .lsdbuf_line_num(line_num), .lsdbuf_start_v(sv), .lsdbuf_start_h(sh),
    .lsdbuf_end_v(ev), .lsdbuf_end_h(eh), .lsdbuf_raddr(raddr),
    .lsdbuf_write_protect(wp), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .done(done),
    .seg_count(seg_count)
  );

  lsd_buffer_reader #(.RD_LATENCY(3)) u_dut3 (
    .psclk(clk), .rst(rst), .start(start3), .lsdbuf_ready(ready3),
    .lsdbuf_line_num(line_num3), .lsdbuf_start_v(sv3), .lsdbuf_start_h(sh3),
    .lsdbuf_end_v(ev3), .lsdbuf_end_h(eh3), .lsdbuf_raddr(raddr3),
    .lsdbuf_write_protect(wp3), .m_valid(m_valid3), .m_ready(m_ready3),
    .m_data(m_data3), .m_last(m_last3), .busy(busy3), .done(done3),
    .seg_count(seg_count3)
  );

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int line_num;
    int ready_delay;
    int stall_beat;
    int stall_len;
    bit start_mid;
    int exp_wp_cycles;
  } vec_t;

  // One frame transfer on the latency-1 instance, checked beat by beat.
  task automatic run_vec(input string tag, input vec_t v);
    int cyc = 0, beat = 0, wp_c = 0, stall_cnt = 0;
    int lock_cyc = -1, hs_cyc = -1, done_cyc = -1;
    bit seen_done = 0, stall_done = 0, arm_ok = 1;
    logic [63:0] snap_d = '0;
    logic        snap_l = 1'b0;
    logic [AW-1:0] snap_a = '0;

    m_ready      = 1'b1;
    line_num     = AW'(v.line_num);
    lsdbuf_ready = (v.ready_delay == 0);
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < v.ready_delay; i++) begin
      arm_ok &= busy & ~wp;
      tick();
    end
    lsdbuf_ready = 1'b1;
    if (v.ready_delay > 0) check({tag, "_arm_hold"}, 96'(arm_ok), 96'd1);

    while (cyc < 300 && !seen_done) begin
      start = 1'b0;
      if (wp) begin
        wp_c++;
        if (lock_cyc < 0) begin
          lock_cyc = cyc;
          lsdbuf_ready = 1'b0;  // must be ignored once locked
        end
      end
      if (done) begin
        seen_done = 1;
        done_cyc  = cyc;
        check({tag, "_wp_at_done"}, 96'(wp), 96'd0);
        check({tag, "_seg_count"}, 96'(seg_count), 96'(v.line_num));
      end
      if (m_valid) begin
        if (v.start_mid && beat == 1) start = 1'b1;
        if (beat == v.stall_beat && !stall_done) begin
          if (stall_cnt == 0) begin
            snap_d = m_data; snap_l = m_last; snap_a = raddr;
          end else begin
            check({tag, "_stall_hold"}, {m_data, 19'(m_last), 13'(raddr)},
                  {snap_d, 19'(snap_l), 13'(snap_a)});
          end
          if (stall_cnt < v.stall_len) begin
            m_ready = 1'b0;
            stall_cnt++;
          end else begin
            m_ready = 1'b1;
            stall_done = 1;
          end
        end
        if (m_ready) begin
          check($sformatf("%s_data%0d", tag, beat), 96'(m_data), 96'(exp_beat(beat)));
          check($sformatf("%s_last%0d", tag, beat), 96'(m_last), 96'(beat == v.line_num - 1));
          check($sformatf("%s_raddr%0d", tag, beat), 96'(raddr), 96'(beat));
          hs_cyc = cyc;
          beat++;
        end
      end
      if (!seen_done) begin
        tick();
        cyc++;
      end
    end

    check({tag, "_done_seen"}, 96'(seen_done), 96'd1);
    check({tag, "_beats"}, 96'(beat), 96'(v.line_num));
    check({tag, "_wp_cycles"}, 96'(wp_c), 96'(v.exp_wp_cycles));
    if (v.line_num == 0) check({tag, "_done_lat"}, 96'(done_cyc - lock_cyc), 96'd1);
    else                 check({tag, "_done_lat"}, 96'(done_cyc - hs_cyc), 96'd1);
    tick();
    check({tag, "_idle_after"}, 96'({done, busy, m_valid, wp}), 96'd0);
  endtask

  vec_t vecs[5];

  initial begin
    int hs, beat, bad, wp_c, last_ra, max_ra, lasts;
    bit found, seen;

    vecs[0] = '{line_num: 3, ready_delay: 0,  stall_beat: -1, stall_len: 0, start_mid: 0, exp_wp_cycles: 7};
    vecs[1] = '{line_num: 0, ready_delay: 0,  stall_beat: -1, stall_len: 0, start_mid: 0, exp_wp_cycles: 1};
    vecs[2] = '{line_num: 4, ready_delay: 0,  stall_beat: 1,  stall_len: 5, start_mid: 0, exp_wp_cycles: 14};
    vecs[3] = '{line_num: 2, ready_delay: 20, stall_beat: -1, stall_len: 0, start_mid: 1, exp_wp_cycles: 5};
    vecs[4] = '{line_num: 1, ready_delay: 0,  stall_beat: -1, stall_len: 0, start_mid: 0, exp_wp_cycles: 3};

    rst = 1'b1; start = 1'b0; lsdbuf_ready = 1'b0; m_ready = 1'b1; line_num = '0;
    start3 = 1'b0; ready3 = 1'b0; m_ready3 = 1'b1; line_num3 = '0;
    repeat (3) tick();
    check("reset_ctrl", 96'({m_valid, wp, m_last, done, busy}), 96'd0);
    check("reset_data", 96'({m_data, raddr, seg_count}), 96'd0);
    check("reset_ctrl3", 96'({m_valid3, wp3, m_last3, done3, busy3}), 96'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec($sformatf("v%0d", i), vecs[i]);

    // Reset while beat 2 of 4 is being offered.
    line_num = AW'(4); lsdbuf_ready = 1'b1; m_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    hs = 0; found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (m_valid) begin
        if (hs == 2) begin
          found = 1;
          m_ready = 1'b0;
        end else hs++;
      end
      if (!found) tick();
    end
    check("rst_reached_beat2", 96'(found), 96'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_ctrl", 96'({m_valid, wp, m_last, done, busy}), 96'd0);
    check("rst_mid_data", 96'({m_data, raddr, seg_count}), 96'd0);
    tick();
    run_vec("after_rst", '{line_num: 4, ready_delay: 0, stall_beat: -1, stall_len: 0,
                           start_mid: 0, exp_wp_cycles: 9});

    // Full-depth frame on the latency-3 instance.
    line_num3 = AW'(4095); ready3 = 1'b1; m_ready3 = 1'b1; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    beat = 0; bad = 0; wp_c = 0; last_ra = -1; max_ra = 0; lasts = 0; seen = 0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      if (wp3) wp_c++;
      if (int'(raddr3) > max_ra) max_ra = int'(raddr3);
      if (m_valid3) begin
        if (m_data3 !== exp_beat(beat)) bad++;
        if (int'(raddr3) != beat) bad++;
        if (m_last3) lasts++;
        if (m_last3 !== (beat == 4094)) bad++;
        last_ra = int'(raddr3);
        beat++;
      end
      if (done3) seen = 1;
      else tick();
    end
    check("l3_done_seen", 96'(seen), 96'd1);
    check("l3_beats", 96'(beat), 96'd4095);
    check("l3_bad_beats", 96'(bad), 96'd0);
    check("l3_last_raddr", 96'(last_ra), 96'd4094);
    check("l3_max_raddr", 96'(max_ra), 96'd4094);
    check("l3_last_count", 96'(lasts), 96'd1);
    check("l3_wp_cycles", 96'(wp_c), 96'd16381);
    check("l3_seg_count", 96'(seg_count3), 96'd4095);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
